// File: rtl/tqvp_arb_pkg.sv
// Shared types and constants for the two-requester peripheral-port arbiter.
package tqvp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam logic [1:0]  NO_ACCESS = 2'b11;
  localparam logic [1:0]  SZ8       = 2'b00;
  localparam logic [1:0]  SZ16      = 2'b01;
  localparam logic [1:0]  SZ32      = 2'b10;
  localparam logic [31:0] ERR_DATA  = 32'hFFFF_FFFF;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // True when a size field requests an actual 8/16/32-bit transfer.
  function automatic logic is_access(input logic [1:0] sz);
    return (sz == SZ8) || (sz == SZ16) || (sz == SZ32);
  endfunction

endpackage

// File: rtl/tqvp_arb_req_slot.sv
// One-deep command slot for a single requester: pending flag, captured
// command with write-over-read precedence, and sticky overrun flag.
module tqvp_arb_req_slot
  import tqvp_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  write_n,
  input  logic [1:0]  read_n,
  input  logic        clr,
  output logic        pending,
  output logic [5:0]  cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic [1:0]  cmd_write_n,
  output logic [1:0]  cmd_read_n,
  output logic        ovr
);

  logic accept;

  // A strobe arriving in the completion cycle refills the slot.
  assign accept = req && (!pending || clr);

  // Capture commands, track pending and overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      ovr         <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_write_n <= NO_ACCESS;
      cmd_read_n  <= NO_ACCESS;
    end else begin
      if (accept) begin
        pending     <= 1'b1;
        cmd_addr    <= addr;
        cmd_wdata   <= wdata;
        cmd_write_n <= write_n;
        cmd_read_n  <= is_access(write_n) ? NO_ACCESS : read_n;
      end else if (clr) begin
        pending <= 1'b0;
      end
      if (req && pending && !clr) begin
        ovr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tqvp_access_arbiter.sv
// Round-robin arbiter sharing one peripheral register port between
// requester A (core bridge) and requester B (internal sequencer).
module tqvp_access_arbiter
  import tqvp_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [5:0]  a_addr,
  input  logic [31:0] a_wdata,
  input  logic [1:0]  a_write_n,
  input  logic [1:0]  a_read_n,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  output logic        a_ovr,
  input  logic        b_req,
  input  logic [5:0]  b_addr,
  input  logic [31:0] b_wdata,
  input  logic [1:0]  b_write_n,
  input  logic [1:0]  b_read_n,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        b_ovr,
  output logic [5:0]  p_address,
  output logic [31:0] p_data_in,
  output logic [1:0]  p_data_write_n,
  output logic [1:0]  p_data_read_n,
  input  logic [31:0] p_data_out,
  input  logic        p_data_ready
);

  logic        a_pend, b_pend;
  logic [5:0]  a_cmd_addr, b_cmd_addr;
  logic [31:0] a_cmd_wdata, b_cmd_wdata;
  logic [1:0]  a_cmd_write_n, b_cmd_write_n;
  logic [1:0]  a_cmd_read_n, b_cmd_read_n;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [5:0]  p_address_d;
  logic [31:0] p_data_in_d;
  logic [1:0]  p_data_write_n_d, p_data_read_n_d;

  logic        sel_b;
  logic [5:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_write_n, sel_read_n;

  tqvp_arb_req_slot u_slot_a (
    .clk(clk), .rst(rst), .req(a_req), .addr(a_addr), .wdata(a_wdata),
    .write_n(a_write_n), .read_n(a_read_n), .clr(a_ack),
    .pending(a_pend), .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .cmd_write_n(a_cmd_write_n), .cmd_read_n(a_cmd_read_n), .ovr(a_ovr)
  );

  tqvp_arb_req_slot u_slot_b (
    .clk(clk), .rst(rst), .req(b_req), .addr(b_addr), .wdata(b_wdata),
    .write_n(b_write_n), .read_n(b_read_n), .clr(b_ack),
    .pending(b_pend), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .cmd_write_n(b_cmd_write_n), .cmd_read_n(b_cmd_read_n), .ovr(b_ovr)
  );

  assign a_ack   = (state_q == DONE) && (grant_q == REQ_A);
  assign b_ack   = (state_q == DONE) && (grant_q == REQ_B);
  assign a_rdata = rdata_q;
  assign b_rdata = rdata_q;
  assign a_err   = err_q;
  assign b_err   = err_q;

  // Pick the next owner: B only if it is alone or it is B's turn.
  always_comb begin
    sel_b       = b_pend && (!a_pend || (last_q == REQ_A));
    sel_addr    = sel_b ? b_cmd_addr    : a_cmd_addr;
    sel_wdata   = sel_b ? b_cmd_wdata   : a_cmd_wdata;
    sel_write_n = sel_b ? b_cmd_write_n : a_cmd_write_n;
    sel_read_n  = sel_b ? b_cmd_read_n  : a_cmd_read_n;
  end

  // Next-state and datapath updates for IDLE -> ISSUE -> DONE.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    cnt_d            = cnt_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    p_address_d      = p_address;
    p_data_in_d      = p_data_in;
    p_data_write_n_d = p_data_write_n;
    p_data_read_n_d  = p_data_read_n;
    unique case (state_q)
      IDLE: begin
        if (a_pend || b_pend) begin
          grant_d = sel_b ? REQ_B : REQ_A;
          last_d  = sel_b ? REQ_B : REQ_A;
          cnt_d   = '0;
          if (!is_access(sel_write_n) && !is_access(sel_read_n)) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            p_address_d      = sel_addr;
            p_data_in_d      = sel_wdata;
            p_data_write_n_d = sel_write_n;
            p_data_read_n_d  = sel_read_n;
            state_d          = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (p_data_ready || (cnt_q == 8'(TIMEOUT - 1))) begin
          if (p_data_ready) begin
            rdata_d = is_access(p_data_read_n) ? p_data_out : '0;
            err_d   = 1'b0;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
          end
          p_address_d      = '0;
          p_data_in_d      = '0;
          p_data_write_n_d = NO_ACCESS;
          p_data_read_n_d  = NO_ACCESS;
          state_d          = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        p_address_d      = '0;
        p_data_in_d      = '0;
        p_data_write_n_d = NO_ACCESS;
        p_data_read_n_d  = NO_ACCESS;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= REQ_A;
      last_q         <= REQ_B;
      cnt_q          <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      p_address      <= '0;
      p_data_in      <= '0;
      p_data_write_n <= NO_ACCESS;
      p_data_read_n  <= NO_ACCESS;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      p_address      <= p_address_d;
      p_data_in      <= p_data_in_d;
      p_data_write_n <= p_data_write_n_d;
      p_data_read_n  <= p_data_read_n_d;
    end
  end

endmodule
